// File: rtl/seg7_pkg.sv
// Shared glyph table, FSM encoding and sizing constants for the 7-segment scan driver.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIG_W      = 4;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  // BCD value to glyph; non-decimal codes render as a dash
  function automatic logic [6:0] bcd_glyph(input logic [DIG_W-1:0] v);
    logic [6:0] g;
    case (v)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_DASH;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD-to-segment decode for one digit, with a blank override.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [DIG_W-1:0] bcd_i,
  input  logic             blank_i,
  output logic [6:0]       seg_o
);

  // Blanked digits light nothing; otherwise look up the glyph
  always_comb begin
    seg_o = SEG_OFF;
    if (!blank_i) seg_o = bcd_glyph(bcd_i);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver: per-frame capture,
// ghost-blank gap before each digit, leading-zero suppression, blinking colon.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits_i,
  input  logic        lz_blank_en,
  input  logic        colon_en,
  input  logic        blink_tick,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [3:0]  an_o,
  output logic        frame_start_o
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  // With no blank phase every digit starts directly in SHOW
  localparam state_e FIRST_ST = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;

  localparam logic [6:0] SEG_MASK = {7{ACTIVE_LOW}};
  localparam logic [3:0] AN_MASK  = {4{ACTIVE_LOW}};

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  run_q, run_d;
  logic [15:0]           frame_q, frame_d;
  logic                  col_ph_q, col_ph_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [3:0]            an_q, an_d;
  logic                  frame_start_q, frame_start_d;

  logic [NUM_DIGITS-1:0][DIG_W-1:0] dig;
  logic [NUM_DIGITS-1:0]            dig_blank;
  logic [NUM_DIGITS-1:0][6:0]       dig_seg;

  logic       show_d;
  logic [6:0] seg_act;
  logic [3:0] an_act;
  logic       dp_act;
  logic       lz_run;

  // Scan sequencer: BLANK/SHOW per digit, idx wraps naturally at 3.
  // run_q holds off the first real cycle until one edge after reset so that
  // the very first digit-0 cycle also raises frame_start and captures.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    run_d   = 1'b1;
    if (!run_q) begin
      state_d = FIRST_ST;
      idx_d   = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = FIRST_ST;
            idx_d   = idx_q + 2'd1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Frame capture on entry to the first cycle of digit 0; colon phase tracking
  always_comb begin
    frame_start_d = (state_d == FIRST_ST) && (idx_d == 2'd0) && (cnt_d == '0);
    frame_d       = frame_start_d ? digits_i : frame_q;
    if (!colon_en)       col_ph_d = 1'b1;
    else if (blink_tick) col_ph_d = ~col_ph_q;
    else                 col_ph_d = col_ph_q;
  end

  // Leading-zero suppression over the frame being displayed; rightmost digit always shown
  always_comb begin
    dig_blank = '0;
    lz_run    = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      lz_run       = lz_run & (dig[k] == '0);
      dig_blank[k] = lz_blank_en & lz_run & (k != NUM_DIGITS - 1);
    end
  end

  // One decoder per digit position; digit0 sits in the top nibble
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
    assign dig[k] = frame_d[(NUM_DIGITS-1-k)*DIG_W +: DIG_W];
    seg7_decode u_dec (
      .bcd_i   (dig[k]),
      .blank_i (dig_blank[k]),
      .seg_o   (dig_seg[k])
    );
  end

  // Output values for the upcoming cycle, polarity applied last
  always_comb begin
    show_d  = (state_d == ST_SHOW);
    an_act  = show_d ? (4'b1000 >> idx_d) : 4'b0000;
    seg_act = show_d ? dig_seg[idx_d] : SEG_OFF;
    dp_act  = show_d && (idx_d == 2'd1) && colon_en && col_ph_d;
    seg_d   = seg_act ^ SEG_MASK;
    an_d    = an_act ^ AN_MASK;
    dp_d    = dp_act ^ ACTIVE_LOW;
  end

  // All state and output registers; reset drives outputs inactive immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BLANK;
      idx_q         <= 2'd0;
      cnt_q         <= '0;
      run_q         <= 1'b0;
      frame_q       <= 16'h0000;
      col_ph_q      <= 1'b1;
      seg_q         <= SEG_MASK;
      dp_q          <= ACTIVE_LOW;
      an_q          <= AN_MASK;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      run_q         <= run_d;
      frame_q       <= frame_d;
      col_ph_q      <= col_ph_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg_o         = seg_q;
  assign dp_o          = dp_q;
  assign an_o          = an_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DWELL=4, BLANK=2, active-low outputs.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits_i;
  logic        lz_blank_en;
  logic        colon_en;
  logic        blink_tick;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_start_o;

  int errors = 0;
  int checks = 0;

  seg7_scan_driver #(
    .DWELL_CYCLES (4),
    .BLANK_CYCLES (2),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .digits_i      (digits_i),
    .lz_blank_en   (lz_blank_en),
    .colon_en      (colon_en),
    .blink_tick    (blink_tick),
    .seg_o         (seg_o),
    .dp_o          (dp_o),
    .an_o          (an_o),
    .frame_start_o (frame_start_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low glyphs as seen on the pins
  localparam logic [6:0] L0 = 7'h40, L1 = 7'h79, L2 = 7'h24, L3 = 7'h30, L4 = 7'h19;
  localparam logic [6:0] L5 = 7'h12, L6 = 7'h02, L7 = 7'h78, L8 = 7'h00, L9 = 7'h10;
  localparam logic [6:0] LD = 7'h3F, LO = 7'h7F;

  typedef struct {
    logic [15:0] digits;
    logic        lz;
    logic [27:0] segs;   // {digit0,digit1,digit2,digit3}
  } vec_t;

  vec_t vecs[9];

  // One comparison of {frame_start, an, seg, dp}
  task automatic check_out(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = {frame_start_o, an_o, seg_o, dp_o};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got fs/an/seg/dp=%b/%h/%h/%b want %b/%h/%h/%b", name,
               act[12], act[11:8], act[7:1], act[0], exp[12], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Advance to the next negedge where frame_start_o is high; bounded
  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start_o && n < 40);
  endtask

  // Check a whole 24-cycle frame; caller is at the negedge of the frame_start cycle
  task automatic check_frame(input string tag, input logic [27:0] segs, input logic dp_on);
    for (int c = 0; c < 24; c++) begin
      int d;
      int ph;
      logic [3:0] ea;
      logic [6:0] es;
      logic       ed;
      if (c > 0) @(negedge clk);
      d  = c / 6;
      ph = c % 6;
      if (ph < 2) begin
        ea = 4'hF;
        es = LO;
        ed = 1'b1;
      end else begin
        ea = ~(4'b1000 >> d);
        es = segs[(3-d)*7 +: 7];
        ed = !((d == 1) && dp_on);
      end
      check_out($sformatf("%s cyc%0d", tag, c), {(c == 0), ea, es, ed});
    end
  endtask

  initial begin
    int n;

    vecs[0] = '{16'h1234, 1'b0, {L1, L2, L3, L4}};
    vecs[1] = '{16'h0050, 1'b1, {LO, LO, L5, L0}};
    vecs[2] = '{16'h0000, 1'b1, {LO, LO, LO, L0}};
    vecs[3] = '{16'h0A09, 1'b0, {L0, LD, L0, L9}};
    vecs[4] = '{16'h0A09, 1'b1, {LO, LD, L0, L9}};
    vecs[5] = '{16'h5678, 1'b0, {L5, L6, L7, L8}};
    vecs[6] = '{16'h0001, 1'b1, {LO, LO, LO, L1}};
    vecs[7] = '{16'h1000, 1'b1, {L1, L0, L0, L0}};
    vecs[8] = '{16'h9876, 1'b0, {L9, L8, L7, L6}};

    rst_n       = 1'b0;
    digits_i    = 16'h1234;
    lz_blank_en = 1'b0;
    colon_en    = 1'b0;
    blink_tick  = 1'b0;

    // Reset state held
    repeat (2) @(negedge clk);
    check_out("reset hold a", {1'b0, 4'hF, LO, 1'b1});
    @(negedge clk);
    check_out("reset hold b", {1'b0, 4'hF, LO, 1'b1});
    rst_n = 1'b1;

    // Table: each vector captured on the next frame start, then one full frame checked
    for (int i = 0; i < 9; i++) begin
      digits_i    = vecs[i].digits;
      lz_blank_en = vecs[i].lz;
      wait_fs(n);
      check_int($sformatf("vec%0d fs spacing", i), n, 1);
      check_frame($sformatf("vec%0d", i), vecs[i].segs, 1'b0);
    end

    // Input change mid-frame does not disturb the current frame
    digits_i    = 16'h1234;
    lz_blank_en = 1'b0;
    wait_fs(n);
    check_int("midchg fs", n, 1);
    fork
      check_frame("midchg old", {L1, L2, L3, L4}, 1'b0);
      begin
        repeat (4) @(negedge clk);
        digits_i = 16'h5678;
      end
    join
    wait_fs(n);
    check_int("midchg fs2", n, 1);
    check_frame("midchg new", {L5, L6, L7, L8}, 1'b0);

    // Colon: starts in phase 1
    digits_i = 16'h1234;
    colon_en = 1'b1;
    wait_fs(n);
    check_int("colon fs", n, 1);
    check_frame("colon on", {L1, L2, L3, L4}, 1'b1);
    // Tick before the frame start: colon off for the whole next frame
    blink_tick = 1'b1;
    @(negedge clk);
    blink_tick = 1'b0;
    check_frame("colon off", {L1, L2, L3, L4}, 1'b0);
    // Tick coincident with frame start: toggles back on from the next cycle
    @(negedge clk);
    fork
      check_frame("colon tick@fs", {L1, L2, L3, L4}, 1'b1);
      begin
        blink_tick = 1'b1;
        @(negedge clk);
        blink_tick = 1'b0;
      end
    join
    // Colon disabled: dp stays inactive even with ticks
    colon_en = 1'b0;
    @(negedge clk);
    fork
      check_frame("colon dis", {L1, L2, L3, L4}, 1'b0);
      begin
        repeat (9) @(negedge clk);
        blink_tick = 1'b1;
        @(negedge clk);
        blink_tick = 1'b0;
      end
    join

    // Async reset in the middle of digit0 SHOW
    wait_fs(n);
    check_int("rst fs", n, 1);
    repeat (3) @(negedge clk);
    check_out("pre-rst show", {1'b0, 4'b0111, L1, 1'b1});
    #2 rst_n = 1'b0;
    #1 check_out("async rst", {1'b0, 4'hF, LO, 1'b1});
    @(negedge clk);
    check_out("rst held", {1'b0, 4'hF, LO, 1'b1});
    digits_i    = 16'h0050;
    lz_blank_en = 1'b1;
    rst_n       = 1'b1;
    wait_fs(n);
    check_int("post-rst fs", n, 1);
    check_frame("post-rst", {LO, LO, L5, L0}, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
